// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg -- shared CPU front-end definitions.
//   PC_RESET_VECTOR : default fetch address after reset
//   pc_state_e      : fetch-address generator FSM states
// ---------------------------------------------------------------------------
package pc_gen_pkg;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,  // one idle cycle after reset, no request issued
    RUN      = 2'd1,  // issuing fetch groups
    MISALIGN = 2'd2   // a misaligned fetch was sent; wait for a redirect
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// ---------------------------------------------------------------------------
// pc_redirect_buf -- pending-redirect register and redirect priority.
//   clk, rst_n          : clock, asynchronous active-low reset
//   hold                : front-end cannot take a redirect now (stall/boot)
//   exc_valid, exc_addr : live exception redirect
//   br_valid,  br_addr  : live branch redirect
//   redir_valid         : a redirect must be applied this cycle
//   redir_addr          : target of that redirect
// While hold is high, redirects are parked in one pending entry; an exception
// replaces anything parked, a branch never replaces a parked exception.
// When hold drops, the winner is chosen by class: live exception, pending
// exception, live branch, pending branch. The entry is always emptied then.
// ---------------------------------------------------------------------------
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_addr
);

  logic              pend_valid_reg, pend_valid_next;
  logic              pend_exc_reg, pend_exc_next;
  logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;

  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_exc_next   = pend_exc_reg;
    pend_addr_next  = pend_addr_reg;
    redir_valid     = 1'b0;
    redir_addr      = pend_addr_reg;
    if (hold) begin
      if (exc_valid) begin
        pend_valid_next = 1'b1;
        pend_exc_next   = 1'b1;
        pend_addr_next  = exc_addr;
      end else if (br_valid && !(pend_valid_reg && pend_exc_reg)) begin
        pend_valid_next = 1'b1;
        pend_exc_next   = 1'b0;
        pend_addr_next  = br_addr;
      end
    end else begin
      pend_valid_next = 1'b0;
      pend_exc_next   = 1'b0;
      if (exc_valid) begin
        redir_valid = 1'b1;
        redir_addr  = exc_addr;
      end else if (pend_valid_reg && pend_exc_reg) begin
        redir_valid = 1'b1;
        redir_addr  = pend_addr_reg;
      end else if (br_valid) begin
        redir_valid = 1'b1;
        redir_addr  = br_addr;
      end else if (pend_valid_reg) begin
        redir_valid = 1'b1;
        redir_addr  = pend_addr_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_reg <= 1'b0;
      pend_exc_reg   <= 1'b0;
      pend_addr_reg  <= '0;
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_exc_reg   <= pend_exc_next;
      pend_addr_reg  <= pend_addr_next;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch address generator.
//   clk, rst_n               : clock, asynchronous active-low reset
//   stall_i                  : freeze the front-end
//   exc_valid_i, exc_addr_i  : exception redirect (highest priority)
//   br_valid_i,  br_addr_i   : branch redirect
//   req_valid_o, req_ready_i : fetch request handshake
//   req_addr_o               : fetch address (current pc)
//   req_mask_o               : valid slots of the fetch group
//   align_err_o              : req_addr_o not word aligned
// ---------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter int                FETCH_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   exc_valid_i,
  input  logic [ADDR_W-1:0]      exc_addr_i,
  input  logic                   br_valid_i,
  input  logic [ADDR_W-1:0]      br_addr_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [ADDR_W-1:0]      req_addr_o,
  output logic [FETCH_WIDTH-1:0] req_mask_o,
  output logic                   align_err_o
);

  localparam int LOG_FW = $clog2(FETCH_WIDTH);
  localparam int SLOT_W = (LOG_FW > 0) ? LOG_FW : 1;
  // Group size in bytes and the mask that clears the in-group offset.
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(4 * FETCH_WIDTH);
  localparam logic [ADDR_W-1:0] GROUP_MASK = ~(ADDR_W'(4 * FETCH_WIDTH) - ADDR_W'(1));

  pc_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] seq_pc;
  logic [SLOT_W-1:0] slot;
  logic [FETCH_WIDTH-1:0] mask_run;
  logic              hold;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_addr;
  logic              xfer;
  logic              misaligned;

  // BOOT counts as a hold so a redirect seen there is parked and only applied
  // once the FSM is in RUN.
  assign hold = stall_i | (state_reg == BOOT);

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .exc_valid   (exc_valid_i),
    .exc_addr    (exc_addr_i),
    .br_valid    (br_valid_i),
    .br_addr     (br_addr_i),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr)
  );

  // Sequential target: start of the next group, wraps naturally at 2^ADDR_W.
  assign seq_pc     = (pc_reg & GROUP_MASK) + STRIDE;
  assign misaligned = |pc_reg[1:0];
  assign xfer       = req_valid_o & req_ready_i & ~stall_i;
  assign req_addr_o = pc_reg;

  generate
    if (LOG_FW == 0) begin : g_slot_single
      assign slot = '0;
    end else begin : g_slot_multi
      assign slot = pc_reg[LOG_FW+1:2];
    end
  endgenerate

  // Slots before the entry word of the group are not valid.
  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_mask
      assign mask_run[gi] = ((SLOT_W+1)'(gi) >= {1'b0, slot});
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
        pc_next    = RESET_VECTOR;
      end
      RUN: begin
        if (redir_valid) begin
          pc_next = redir_addr;
        end else if (xfer) begin
          if (misaligned) begin
            state_next = MISALIGN;
          end else begin
            pc_next = seq_pc;
          end
        end
      end
      MISALIGN: begin
        if (redir_valid) begin
          state_next = RUN;
          pc_next    = redir_addr;
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_VECTOR;
      end
    endcase
  end

  always_comb begin
    req_valid_o = 1'b0;
    req_mask_o  = '1;
    align_err_o = 1'b0;
    if (state_reg == RUN) begin
      req_valid_o = 1'b1;
      req_mask_o  = mask_run;
      align_err_o = misaligned;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (FETCH_WIDTH=2, ADDR_W=32).
// ---------------------------------------------------------------------------
module tb_pc_gen;

  localparam int          FW = 2;
  localparam logic [31:0] RV = 32'hbfc0_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_i;
  logic          exc_valid_i;
  logic [31:0]   exc_addr_i;
  logic          br_valid_i;
  logic [31:0]   br_addr_i;
  logic          req_valid_o;
  logic          req_ready_i;
  logic [31:0]   req_addr_o;
  logic [FW-1:0] req_mask_o;
  logic          align_err_o;

  int n_vec = 0;
  int n_err = 0;

  pc_gen #(
    .ADDR_W       (32),
    .RESET_VECTOR (RV),
    .FETCH_WIDTH  (FW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .exc_valid_i (exc_valid_i),
    .exc_addr_i  (exc_addr_i),
    .br_valid_i  (br_valid_i),
    .br_addr_i   (br_addr_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_addr_o  (req_addr_o),
    .req_mask_o  (req_mask_o),
    .align_err_o (align_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected slot mask: slot i is valid when i is at or after the entry word.
  function automatic logic [31:0] exp_mask(input logic [31:0] addr);
    logic [31:0] m;
    int entry;
    m = '0;
    entry = int'((addr >> 2) % FW);
    for (int i = 0; i < FW; i++) m[i] = (i >= entry);
    return m;
  endfunction

  // Start of the following fetch group, modulo 2^32.
  function automatic logic [31:0] next_group(input logic [31:0] addr);
    longint unsigned a;
    a = longint'(addr);
    a = (a / (4 * FW) + 1) * (4 * FW);
    return a[31:0];
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = idle after reset, 1 = fetching, 2 = halted on misaligned fetch
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_pv, m_pe;
  logic [31:0] m_pa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_pc   <= RV;
      m_pv   <= 1'b0;
      m_pe   <= 1'b0;
      m_pa   <= '0;
    end else if (m_mode == 0 || stall_i) begin
      if (exc_valid_i) begin
        m_pv <= 1'b1; m_pe <= 1'b1; m_pa <= exc_addr_i;
      end else if (br_valid_i && !(m_pv && m_pe)) begin
        m_pv <= 1'b1; m_pe <= 1'b0; m_pa <= br_addr_i;
      end
      if (m_mode == 0) begin
        m_mode <= 1;
        m_pc   <= RV;
      end
    end else begin
      m_pv <= 1'b0;
      m_pe <= 1'b0;
      if (exc_valid_i) begin
        m_pc <= exc_addr_i; m_mode <= 1;
      end else if (m_pv && m_pe) begin
        m_pc <= m_pa; m_mode <= 1;
      end else if (br_valid_i) begin
        m_pc <= br_addr_i; m_mode <= 1;
      end else if (m_pv) begin
        m_pc <= m_pa; m_mode <= 1;
      end else if (m_mode == 1 && req_ready_i) begin
        if (m_pc % 4 != 0) m_mode <= 2;
        else m_pc <= next_group(m_pc);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 32'(req_valid_o), 32'd0);
      check("rst_align", 32'(align_err_o), 32'd0);
      check("rst_mask", 32'(req_mask_o), 32'h3);
    end else begin
      check("mdl_valid", 32'(req_valid_o), (m_mode == 1) ? 32'd1 : 32'd0);
      if (m_mode == 1) begin
        check("mdl_addr", req_addr_o, m_pc);
        check("mdl_mask", 32'(req_mask_o), exp_mask(m_pc));
        check("mdl_align", 32'(align_err_o), (m_pc % 4 != 0) ? 32'd1 : 32'd0);
      end else begin
        check("mdl_align_idle", 32'(align_err_o), 32'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string name, input logic [31:0] addr, input logic [1:0] mask);
    $display("vec %-12s valid=%0b addr=%h mask=%b align=%0b", name, req_valid_o, req_addr_o, req_mask_o, align_err_o);
    check({name, "_valid"}, 32'(req_valid_o), 32'd1);
    check({name, "_addr"}, req_addr_o, addr);
    check({name, "_mask"}, 32'(req_mask_o), 32'(mask));
  endtask

  task automatic expect_idle(input string name);
    $display("vec %-12s valid=%0b align=%0b", name, req_valid_o, align_err_o);
    check({name, "_valid"}, 32'(req_valid_o), 32'd0);
    check({name, "_align"}, 32'(align_err_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; req_ready_i = 1'b1;
    exc_valid_i = 1'b0; exc_addr_i = '0; br_valid_i = 1'b0; br_addr_i = '0;
    step(); step();
    expect_idle("in_reset");
    check("in_reset_addr", req_addr_o, RV);
    check("in_reset_mask", 32'(req_mask_o), 32'h3);

    // Reset release: one idle cycle, then sequential groups.
    rst_n = 1'b1;
    expect_idle("boot");
    step(); expect_req("seq0", 32'hbfc0_0000, 2'b11);
    step(); expect_req("seq1", 32'hbfc0_0008, 2'b11);
    step(); expect_req("seq2", 32'hbfc0_0010, 2'b11);

    // Branch into the second slot of a group.
    br_valid_i = 1'b1; br_addr_i = 32'h8000_0004;
    step(); br_valid_i = 1'b0;
    expect_req("br_odd", 32'h8000_0004, 2'b10);
    step(); expect_req("br_next", 32'h8000_0008, 2'b11);

    // Back-pressure holds the request; a branch still redirects.
    req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_req("not_ready", 32'h8000_0008, 2'b11);
    end
    br_valid_i = 1'b1; br_addr_i = 32'h0000_1000;
    step(); br_valid_i = 1'b0;
    expect_req("br_noready", 32'h0000_1000, 2'b11);
    req_ready_i = 1'b1;

    // Redirects during a stall are parked; the exception survives a later branch.
    stall_i = 1'b1;
    br_valid_i = 1'b1; br_addr_i = 32'h0000_2000;
    step(); expect_req("stall_br", 32'h0000_1000, 2'b11);
    br_valid_i = 1'b0; exc_valid_i = 1'b1; exc_addr_i = 32'h0000_0380;
    step(); expect_req("stall_exc", 32'h0000_1000, 2'b11);
    exc_valid_i = 1'b0; br_valid_i = 1'b1; br_addr_i = 32'h0000_3000;
    step(); expect_req("stall_br2", 32'h0000_1000, 2'b11);
    br_valid_i = 1'b0; stall_i = 1'b0;
    step(); expect_req("unstall", 32'h0000_0380, 2'b11);

    // Misaligned target: flagged, then halted until an exception.
    br_valid_i = 1'b1; br_addr_i = 32'h0000_1002;
    step(); br_valid_i = 1'b0;
    expect_req("misalign", 32'h0000_1002, 2'b11);
    check("misalign_err", 32'(align_err_o), 32'd1);
    step(); expect_idle("halt0");
    step(); expect_idle("halt1");
    step(); expect_idle("halt2");
    exc_valid_i = 1'b1; exc_addr_i = 32'h0000_0380;
    step(); exc_valid_i = 1'b0;
    expect_req("halt_exit", 32'h0000_0380, 2'b11);
    check("halt_exit_err", 32'(align_err_o), 32'd0);

    // Address wrap at the top of the space.
    br_valid_i = 1'b1; br_addr_i = 32'hffff_fff8;
    step(); br_valid_i = 1'b0;
    expect_req("top", 32'hffff_fff8, 2'b11);
    step(); expect_req("wrap", 32'h0000_0000, 2'b11);

    // Simultaneous redirects: exception wins.
    exc_valid_i = 1'b1; exc_addr_i = 32'h0000_0500;
    br_valid_i = 1'b1;  br_addr_i = 32'h0000_0600;
    step(); exc_valid_i = 1'b0; br_valid_i = 1'b0;
    expect_req("exc_wins", 32'h0000_0500, 2'b11);

    // Reset while a request is outstanding drops it at once.
    req_ready_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    expect_idle("mid_reset");
    check("mid_reset_addr", req_addr_o, RV);
    step();

    // A branch seen during the idle cycle is applied after the first request.
    rst_n = 1'b1; req_ready_i = 1'b1;
    br_valid_i = 1'b1; br_addr_i = 32'h0000_4000;
    step(); br_valid_i = 1'b0;
    expect_req("boot_first", RV, 2'b11);
    step(); expect_req("boot_br", 32'h0000_4000, 2'b11);
    step(); expect_req("boot_br_seq", 32'h0000_4008, 2'b11);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hbfc0_0000, SHALL be the fetch address issued after reset.
REQ-002 Parameter FETCH_WIDTH, default 2, SHALL be the instructions per fetch group, legal values 1, 2 and 4; it SHALL be a power of two.
REQ-003 Parameter ADDR_W, default 32, SHALL be the address width.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 stall_i  in  1  SHALL freeze the pipeline front-end when high.
REQ-007 exc_valid_i  in  1 / exc_addr_i  in  ADDR_W  SHALL be the exception redirect.
REQ-008 br_valid_i  in  1 / br_addr_i  in  ADDR_W  SHALL be the branch redirect.
REQ-009 req_valid_o  out  1 / req_ready_i  in  1  SHALL be the fetch handshake to the I-side.
REQ-010 req_addr_o  out  ADDR_W  SHALL be the fetch address.
REQ-011 req_mask_o  out  FETCH_WIDTH  SHALL be the per-slot valid mask of the group.
REQ-012 align_err_o  out  1  SHALL flag a misaligned req_addr_o.

Function
REQ-013 The FSM SHALL have three states: BOOT, RUN and MISALIGN.
REQ-014 In BOOT, req_valid_o SHALL be 0; BOOT SHALL go to RUN after one cycle with pc=RESET_VECTOR.
REQ-015 In RUN, req_valid_o SHALL be 1, and req_addr_o SHALL equal pc.
REQ-016 A transfer SHALL occur when req_valid_o & req_ready_i & !stall_i.
REQ-017 The group base SHALL be pc with its low log2(FETCH_WIDTH)+2 bits cleared.
REQ-018 req_mask_o bit i SHALL be 1 when i >= pc[log2(FETCH_WIDTH)+1:2].
REQ-019 On a transfer with no redirect, pc SHALL become group base + 4*FETCH_WIDTH, wrapping modulo 2^ADDR_W.
REQ-020 While req_valid_o & !req_ready_i, with no redirect, req_addr_o and req_mask_o SHALL stay stable.
REQ-021 A redirect SHALL override a pending un-accepted request; pc SHALL take the redirect address on the next cycle regardless of req_ready_i.
REQ-022 If exc_valid_i and br_valid_i are high in the same cycle, exc_valid_i SHALL win.
REQ-023 A redirect arriving while stall_i=1 SHALL be captured into a pending register (pend_valid, pend_addr); pc SHALL not change.
REQ-024 A later exception SHALL overwrite a pending branch; a later branch SHALL NOT overwrite a pending exception.
REQ-025 On the first cycle with stall_i=0, a pending redirect SHALL load pc and clear pend_valid; a live redirect in that cycle SHALL take precedence over the pending entry under REQ-022 priority.
REQ-026 align_err_o SHALL equal |req_addr_o[1:0] while req_valid_o=1, and 0 otherwise.
REQ-027 When a misaligned request transfers, the FSM SHALL enter MISALIGN.
REQ-028 In MISALIGN, req_valid_o SHALL be 0 and no sequential advance SHALL occur.
REQ-029 Only a redirect SHALL exit MISALIGN, going to RUN with pc equal to the redirect address.
REQ-030 Redirect latency SHALL be one cycle: redirect in cycle N gives req_addr_o equal to the target in cycle N+1, when not stalled.
REQ-031 A redirect seen in BOOT SHALL be held pending and applied on entry to RUN.

Reset
REQ-032 While rst_n=0, the outputs SHALL be: state=BOOT, pc=RESET_VECTOR, pend_valid=0, req_valid_o=0, align_err_o=0, req_mask_o=all ones.
REQ-033 Reset assertion mid-transfer SHALL abandon the request immediately; no partial state SHALL survive.

Structure
REQ-034 The FSM state enum and the default RESET_VECTOR constant SHALL be placed in the shared CPU package.
REQ-035 A sub-module pc_redirect_buf SHALL hold the pending-redirect register and the priority logic.

Verification
REQ-036 The bench SHALL cover reset release with FETCH_WIDTH=2 and ready=1: addresses SHALL be bfc00000, bfc00008, bfc00010, each with mask 2'b11.
REQ-037 The bench SHALL cover branch to 0x80000004 in RUN: next cycle addr=80000004 and mask=2'b10, then 80000008.
REQ-038 The bench SHALL cover ready=0 for 3 cycles: addr stays constant; then branch to 0x1000 with ready=0: addr=0x1000 next cycle.
REQ-039 The bench SHALL cover stall_i=1 with branch 0x2000, then exception 0x380, then branch 0x3000, then stall_i release: next addr=0x380.
REQ-040 The bench SHALL cover branch to 0x1002: align_err_o=1; after transfer req_valid_o=0 and is held until exception 0x380 arrives, then addr=0x380.
REQ-041 The bench SHALL cover pc=0xfffffff8 with FETCH_WIDTH=2: the next addr SHALL wrap to 0x00000000.
